// File: rtl/mem_access_pkg.sv
// Shared definitions for the core-side memory access master: funct3 codes,
// FSM state encoding and request legality helper.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Unsupported width, store of an unsigned-load code, or misaligned lane.
    function automatic logic funct3_addr_err(input logic [2:0] f3,
                                             input logic       wr,
                                             input logic [1:0] lsb);
        logic err_v;
        case (f3)
            F3_B:    err_v = 1'b0;
            F3_H:    err_v = lsb[0];
            F3_W:    err_v = (lsb != 2'b00);
            F3_BU:   err_v = wr;
            F3_HU:   err_v = wr | lsb[0];
            default: err_v = 1'b1;
        endcase
        return err_v;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane extraction with sign/zero extension for loads, and lane
// merge of store data into the previously read word for SB/SH.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and load extension
    always_comb begin
        byte_s      = 8'h00;
        half_s      = 16'h0000;
        load_data_o = 32'h0000_0000;
        case (addr_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            2'd3:    byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
            F3_W:    load_data_o = word_i;
            F3_BU:   load_data_o = {24'h000000, byte_s};
            F3_HU:   load_data_o = {16'h0000, half_s};
            default: load_data_o = 32'h0000_0000;
        endcase
    end

    // Store merge: SW passes data through, SB/SH patch one lane of the read word
    always_comb begin
        store_word_o = word_i;
        case (funct3_i)
            F3_B: begin
                case (addr_i)
                    2'd0:    store_word_o = {word_i[31:8], wdata_i[7:0]};
                    2'd1:    store_word_o = {word_i[31:16], wdata_i[7:0], word_i[7:0]};
                    2'd2:    store_word_o = {word_i[31:24], wdata_i[7:0], word_i[15:0]};
                    2'd3:    store_word_o = {wdata_i[7:0], word_i[23:0]};
                    default: store_word_o = word_i;
                endcase
            end
            F3_H: begin
                if (addr_i[1]) begin
                    store_word_o = {wdata_i[15:0], word_i[15:0]};
                end else begin
                    store_word_o = {word_i[31:16], wdata_i[15:0]};
                end
            end
            F3_W:    store_word_o = wdata_i;
            default: store_word_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_master.sv
// Converts one RV32I load/store request into word-aligned cycles on a
// single-port memory with combinational read; SB/SH use read-modify-write.
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_Wdata,
    output logic        Resp_Valid,
    output logic [31:0] Resp_Rdata,
    output logic        Resp_Err,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Write_Data,
    output logic        Mem_Write_En,
    input  logic [31:0] Mem_Read_Data
);

    localparam logic [31:0] MEM_WORDS_L = MEM_WORDS[31:0];

    state_t      state_q, state_d;
    logic [31:0] addr_q,  addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q,  word_d;
    logic        err_q,   err_d;

    logic        req_err_s;
    logic [31:0] load_data_s;
    logic [31:0] store_word_s;

    assign req_err_s = funct3_addr_err(Req_Funct3, Req_Write, Req_Addr[1:0])
                     | ({2'b00, Req_Addr[31:2]} >= MEM_WORDS_L);

    mem_lane_align u_align (
        .word_i       (word_q),
        .addr_i       (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data_s),
        .store_word_o (store_word_s)
    );

    // Next-state and request capture
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (Req_Valid) begin
                    addr_d   = Req_Addr;
                    funct3_d = Req_Funct3;
                    write_d  = Req_Write;
                    wdata_d  = Req_Wdata;
                    if (req_err_s) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (Req_Write && (Req_Funct3 == F3_W)) begin
                        err_d   = 1'b0;
                        state_d = ST_WRITE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                word_d = Mem_Read_Data;
                if (write_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'h0000_0000;
            funct3_q <= 3'd0;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            word_q   <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            err_q    <= err_d;
        end
    end

    // Response decode depends only on state and registers
    always_comb begin
        if ((state_q == ST_RESP) && !err_q && !write_q) begin
            Resp_Rdata = load_data_s;
        end else begin
            Resp_Rdata = 32'h0000_0000;
        end
    end

    assign Req_Ready      = (state_q == ST_IDLE);
    assign Resp_Valid     = (state_q == ST_RESP);
    assign Resp_Err       = (state_q == ST_RESP) & err_q;
    assign Mem_Addr       = {addr_q[31:2], 2'b00};
    assign Mem_Write_Data = store_word_s;
    // Gating with reset drops a write whose cycle is being aborted
    assign Mem_Write_En   = (state_q == ST_WRITE) & ~reset;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a 64-word memory model.
module tb_mem_access_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [2:0]  Req_Funct3;
    logic [31:0] Req_Addr;
    logic [31:0] Req_Wdata;
    logic        Resp_Valid;
    logic [31:0] Resp_Rdata;
    logic        Resp_Err;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Write_Data;
    logic        Mem_Write_En;
    logic [31:0] Mem_Read_Data;

    logic [31:0] mem     [0:63];
    logic [31:0] exp_mem [0:63];
    logic        mem_init;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0]  rv_v, we_v, re_v;
    logic [31:0] rd_a [0:4];
    logic [31:0] wd_a [0:4];
    logic [31:0] ma_a [0:4];

    mem_access_master #(.MEM_WORDS(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .Req_Valid      (Req_Valid),
        .Req_Ready      (Req_Ready),
        .Req_Write      (Req_Write),
        .Req_Funct3     (Req_Funct3),
        .Req_Addr       (Req_Addr),
        .Req_Wdata      (Req_Wdata),
        .Resp_Valid     (Resp_Valid),
        .Resp_Rdata     (Resp_Rdata),
        .Resp_Err       (Resp_Err),
        .Mem_Addr       (Mem_Addr),
        .Mem_Write_Data (Mem_Write_Data),
        .Mem_Write_En   (Mem_Write_En),
        .Mem_Read_Data  (Mem_Read_Data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h80FF_7F01 : (32'h1000_0000 + 32'(i));
    endfunction

    assign Mem_Read_Data = (Mem_Addr[31:8] == 24'h0) ? mem[Mem_Addr[7:2]] : 32'h0000_0000;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (Mem_Write_En && (Mem_Addr[31:8] == 24'h0)) begin
            mem[Mem_Addr[7:2]] <= Mem_Write_Data;
        end
    end

    task automatic sample(input int k);
        rv_v[k] = Resp_Valid;
        re_v[k] = Resp_Err;
        we_v[k] = Mem_Write_En;
        rd_a[k] = Resp_Rdata;
        wd_a[k] = Mem_Write_Data;
        ma_a[k] = Mem_Addr;
    endtask

    // Issue one request from IDLE and record cycles 0..4 relative to accept.
    task automatic do_req(input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
        Req_Write  = w;
        Req_Funct3 = f3;
        Req_Addr   = a;
        Req_Wdata  = d;
        Req_Valid  = 1'b1;
        #1;
        sample(0);
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) Req_Valid = 1'b0;
            sample(k);
        end
    endtask

    task automatic test_reset;
        mem_init   = 1'b1;
        reset      = 1'b1;
        Req_Valid  = 1'b0;
        Req_Write  = 1'b0;
        Req_Funct3 = 3'd0;
        Req_Addr   = 32'h0;
        Req_Wdata  = 32'h0;
        for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        reset    = 1'b0;
        #1;
        n_vec++; if (Req_Ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", Req_Ready); end
        n_vec++; if (Resp_Valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", Resp_Valid); end
        n_vec++; if (Resp_Err !== 1'b0) begin n_err++; $display("FAIL reset_resp_err: got %b want 0", Resp_Err); end
        n_vec++; if (Resp_Rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", Resp_Rdata); end
        n_vec++; if (Mem_Write_En !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", Mem_Write_En); end
        n_vec++; if (Mem_Addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", Mem_Addr); end
    endtask

    task automatic test_loads;
        logic [2:0]  f3_t  [0:7] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd0, 3'd5};
        logic [31:0] adr_t [0:7] = '{32'h08, 32'h0A, 32'h0B, 32'h0A, 32'h0A, 32'h08, 32'h0B, 32'h08};
        logic [31:0] exp_t [0:7] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                                     32'h0000_80FF, 32'h80FF_7F01, 32'hFFFF_FF80, 32'h0000_7F01};
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, f3_t[i], adr_t[i], 32'hFFFF_FFFF);
            n_vec++; if (rv_v !== 5'b00100) begin n_err++; $display("FAIL load%0d_valid_cycles: got %b want 00100", i, rv_v); end
            n_vec++; if (rd_a[2] !== exp_t[i]) begin n_err++; $display("FAIL load%0d_rdata: got %h want %h", i, rd_a[2], exp_t[i]); end
            n_vec++; if (re_v[2] !== 1'b0) begin n_err++; $display("FAIL load%0d_err: got %b want 0", i, re_v[2]); end
            n_vec++; if (we_v !== 5'b00000) begin n_err++; $display("FAIL load%0d_we: got %b want 00000", i, we_v); end
        end
    endtask

    task automatic test_sub_word_store;
        do_req(1'b1, 3'd0, 32'h09, 32'h1234_56AB);
        exp_mem[2] = 32'h80FF_AB01;
        n_vec++; if (we_v !== 5'b00100) begin n_err++; $display("FAIL sb_we_cycles: got %b want 00100", we_v); end
        n_vec++; if (wd_a[2] !== 32'h80FF_AB01) begin n_err++; $display("FAIL sb_wdata: got %h want 80ffab01", wd_a[2]); end
        n_vec++; if (ma_a[2] !== 32'h08) begin n_err++; $display("FAIL sb_addr: got %h want 00000008", ma_a[2]); end
        n_vec++; if (rv_v !== 5'b01000) begin n_err++; $display("FAIL sb_valid_cycles: got %b want 01000", rv_v); end
        n_vec++; if (rd_a[3] !== 32'h0 || re_v[3] !== 1'b0) begin n_err++; $display("FAIL sb_resp: got %h/%b want 0/0", rd_a[3], re_v[3]); end
        do_req(1'b0, 3'd2, 32'h08, 32'h0);
        n_vec++; if (rd_a[2] !== 32'h80FF_AB01) begin n_err++; $display("FAIL sb_readback: got %h want 80ffab01", rd_a[2]); end
        do_req(1'b1, 3'd1, 32'h06, 32'hFFFF_5678);
        exp_mem[1] = 32'h5678_0001;
        n_vec++; if (wd_a[2] !== 32'h5678_0001 || we_v !== 5'b00100) begin n_err++; $display("FAIL sh_wdata: got %h/%b want 56780001/00100", wd_a[2], we_v); end
        do_req(1'b0, 3'd1, 32'h06, 32'h0);
        n_vec++; if (rd_a[2] !== 32'h0000_5678) begin n_err++; $display("FAIL sh_readback: got %h want 00005678", rd_a[2]); end
    endtask

    task automatic test_word_store;
        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        exp_mem[4] = 32'hDEAD_BEEF;
        n_vec++; if (we_v !== 5'b00010) begin n_err++; $display("FAIL sw_we_cycles: got %b want 00010", we_v); end
        n_vec++; if (ma_a[1] !== 32'h10 || wd_a[1] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw_bus: got %h/%h want 00000010/deadbeef", ma_a[1], wd_a[1]); end
        n_vec++; if (rv_v !== 5'b00100) begin n_err++; $display("FAIL sw_valid_cycles: got %b want 00100", rv_v); end
        n_vec++; if (rd_a[2] !== 32'h0 || re_v[2] !== 1'b0) begin n_err++; $display("FAIL sw_resp: got %h/%b want 0/0", rd_a[2], re_v[2]); end
        n_vec++; if (mem[4] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
    endtask

    task automatic test_errors;
        logic        w_t   [0:5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3_t  [0:5] = '{3'd2, 3'd1, 3'd4, 3'd2, 3'd3, 3'd5};
        logic [31:0] adr_t [0:5] = '{32'h06, 32'h03, 32'h08, 32'h100, 32'h00, 32'h04};
        int bad;
        for (int i = 0; i < 6; i++) begin
            do_req(w_t[i], f3_t[i], adr_t[i], 32'h5555_AAAA);
            n_vec++; if (rv_v !== 5'b00010) begin n_err++; $display("FAIL err%0d_valid_cycles: got %b want 00010", i, rv_v); end
            n_vec++; if (re_v[1] !== 1'b1 || rd_a[1] !== 32'h0) begin n_err++; $display("FAIL err%0d_resp: got %b/%h want 1/0", i, re_v[1], rd_a[1]); end
            n_vec++; if (we_v !== 5'b00000) begin n_err++; $display("FAIL err%0d_we: got %b want 00000", i, we_v); end
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL err_mem_unchanged: got %0d changed words want 0", bad); end
    endtask

    task automatic test_reset_in_write;
        Req_Write  = 1'b1;
        Req_Funct3 = 3'd1;
        Req_Addr   = 32'h0E;
        Req_Wdata  = 32'h0000_1234;
        Req_Valid  = 1'b1;
        @(posedge clk); #1;
        Req_Valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (Mem_Write_En !== 1'b1 || Mem_Write_Data !== 32'h1234_0003) begin n_err++; $display("FAIL rstw_pre: got %b/%h want 1/12340003", Mem_Write_En, Mem_Write_Data); end
        reset = 1'b1;
        #1;
        n_vec++; if (Mem_Write_En !== 1'b0) begin n_err++; $display("FAIL rstw_gate: got %b want 0", Mem_Write_En); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_vec++; if (Req_Ready !== 1'b1 || Resp_Valid !== 1'b0 || Mem_Addr !== 32'h0) begin n_err++; $display("FAIL rstw_idle: got ready %b valid %b addr %h want 1 0 0", Req_Ready, Resp_Valid, Mem_Addr); end
        @(posedge clk); #1;
        n_vec++; if (Resp_Valid !== 1'b0) begin n_err++; $display("FAIL rstw_no_resp: got %b want 0", Resp_Valid); end
        n_vec++; if (mem[3] !== exp_mem[3]) begin n_err++; $display("FAIL rstw_mem: got %h want %h", mem[3], exp_mem[3]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  rv_b, rdy_b;
        logic [31:0] rd_b [0:7];
        Req_Write  = 1'b0;
        Req_Funct3 = 3'd2;
        Req_Addr   = 32'h08;
        Req_Valid  = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            rv_b[k]  = Resp_Valid;
            rdy_b[k] = Req_Ready;
            rd_b[k]  = Resp_Rdata;
            @(posedge clk); #1;
            if (k == 0) Req_Addr = 32'h10;
            if (k == 5) Req_Valid = 1'b0;
        end
        n_vec++; if (rv_b !== 8'b0010_0100) begin n_err++; $display("FAIL b2b_valid_cycles: got %b want 00100100", rv_b); end
        n_vec++; if (rdy_b !== 8'b1100_1001) begin n_err++; $display("FAIL b2b_ready_cycles: got %b want 11001001", rdy_b); end
        n_vec++; if ($countones(rv_b) !== 2) begin n_err++; $display("FAIL b2b_pulse_count: got %0d want 2", $countones(rv_b)); end
        n_vec++; if (rd_b[2] !== exp_mem[2] || rd_b[5] !== exp_mem[4]) begin n_err++; $display("FAIL b2b_rdata: got %h/%h want %h/%h", rd_b[2], rd_b[5], exp_mem[2], exp_mem[4]); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sub_word_store();
        test_word_store();
        test_errors();
        test_reset_in_write();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
